// File: rtl/pcie_mwr_tx.sv
// Posted MWr TLP generator on a 16-bit VC0 port: checks credits, then requests and streams the TLP without gaps once tx_rdy grants.
// Header plus 2*len payload words; 4DW headers for nonzero upper addresses when PCIE_MWR_ADDR64_EN is defined.
module pcie_mwr_tx (
  input  logic        pcie_clk,
  input  logic        rstn,
  input  logic [7:0]  bus_num,
  input  logic [4:0]  dev_num,
  input  logic [2:0]  func_num,
  input  logic        start,
  input  logic [29:0] dma_addr,
  input  logic [5:0]  dma_len,
`ifdef PCIE_MWR_ADDR64_EN
  input  logic [31:0] dma_addr_hi,
`endif
  output logic [5:0]  buf_adr,
  input  logic [15:0] buf_dat,
  output logic        tx_req,
  output logic        tx_st,
  output logic        tx_end,
  input  logic        tx_rdy,
  output logic [15:0] tx_data,
  input  logic [8:0]  tx_ca_ph,
  input  logic [12:0] tx_ca_pd,
  input  logic        tx_ca_p_recheck,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, HDR, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  cnt;
  logic        err_q;
  logic [29:0] addr_q;
  logic [5:0]  len_q;
  logic [15:0] rid_q;
  logic [31:0] addr_hi_q;
  logic [31:0] addr_lo;
  logic        is64;
  logic [6:0]  hdr_last;
  logic [6:0]  data_last;
  logic [12:0] pd_need;
  logic        len_ok;
  logic        launch;
  logic        credit_ok;
  logic [3:0]  last_be;
  logic [15:0] hdr_word;

  assign len_ok    = (dma_len != 6'd0) && (dma_len <= 6'd32);
  assign launch    = (state == IDLE) && start && len_ok;
  assign addr_lo   = {addr_q, 2'b00};
  assign is64      = |addr_hi_q;
  assign hdr_last  = is64 ? 7'd7 : 7'd5;
  assign data_last = {len_q, 1'b0} - 7'd1;
  assign pd_need   = ({7'd0, len_q} + 13'd3) >> 2;
  assign last_be   = (len_q == 6'd1) ? 4'h0 : 4'hF;
  assign credit_ok = (tx_ca_ph[8] || (tx_ca_ph != 9'd0)) &&
                     (tx_ca_pd[12] || (tx_ca_pd >= pd_need));

  always_ff @(posedge pcie_clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = CHECK;
      CHECK:   if (credit_ok) state_nxt = REQ;
      // A grant in the same cycle as a recheck still wins: the credits were already committed.
      REQ:     if (tx_rdy) state_nxt = HDR;
               else if (tx_ca_p_recheck) state_nxt = CHECK;
      HDR:     if (cnt == hdr_last) state_nxt = DATA;
      DATA:    if (cnt == data_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= 7'd0;
      err_q  <= 1'b0;
      addr_q <= 30'd0;
      len_q  <= 6'd0;
      rid_q  <= 16'd0;
    end else begin
      cnt   <= (state_nxt != state) ? 7'd0 : cnt + 7'd1;
      err_q <= (state == IDLE) && start && !len_ok;
      if (launch) begin
        addr_q <= dma_addr;
        len_q  <= dma_len;
        rid_q  <= {bus_num, dev_num, func_num};
      end
    end
  end

`ifdef PCIE_MWR_ADDR64_EN
  always_ff @(posedge pcie_clk or negedge rstn) begin
    if (!rstn)       addr_hi_q <= 32'd0;
    else if (launch) addr_hi_q <= dma_addr_hi;
  end
`else
  assign addr_hi_q = 32'd0;
`endif

  always_comb begin
    hdr_word = 16'h0000;
    case (cnt[2:0])
      3'd0: hdr_word = is64 ? 16'h6000 : 16'h4000;
      3'd1: hdr_word = {10'd0, len_q};
      3'd2: hdr_word = rid_q;
      3'd3: hdr_word = {8'h00, last_be, 4'hF};
      3'd4: hdr_word = is64 ? addr_hi_q[31:16] : addr_lo[31:16];
      3'd5: hdr_word = is64 ? addr_hi_q[15:0]  : addr_lo[15:0];
      3'd6: hdr_word = addr_lo[31:16];
      3'd7: hdr_word = addr_lo[15:0];
      default: hdr_word = 16'h0000;
    endcase
  end

  // Outputs decode straight from the async-reset state so reset clears them without a clock.
  assign tx_req  = (state == REQ);
  assign tx_st   = (state == HDR) && (cnt == 7'd0);
  assign tx_end  = (state == DATA) && (cnt == data_last);
  assign buf_adr = (state == DATA) ? cnt[5:0] : 6'd0;
  assign tx_data = (state == HDR)  ? hdr_word :
                   (state == DATA) ? buf_dat  : 16'h0000;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign err     = err_q;

endmodule

// File: tb/tb_pcie_mwr_tx.sv
// Randomized scoreboard bench for pcie_mwr_tx; expected TLP words are built from the MWr layout rules.
module tb_pcie_mwr_tx;

`ifdef PCIE_MWR_ADDR64_EN
  localparam bit ADDR64 = 1'b1;
`else
  localparam bit ADDR64 = 1'b0;
`endif

  logic        pcie_clk = 1'b0;
  logic        rstn = 1'b1;
  logic [7:0]  bus_num = 8'd0;
  logic [4:0]  dev_num = 5'd0;
  logic [2:0]  func_num = 3'd0;
  logic        start = 1'b0;
  logic [29:0] dma_addr = 30'd0;
  logic [5:0]  dma_len = 6'd0;
  logic [31:0] dma_addr_hi = 32'd0;
  logic [5:0]  buf_adr;
  logic [15:0] buf_dat;
  logic        tx_req, tx_st, tx_end;
  logic        tx_rdy = 1'b0;
  logic [15:0] tx_data;
  logic [8:0]  tx_ca_ph = 9'h100;
  logic [12:0] tx_ca_pd = 13'h1000;
  logic        tx_ca_p_recheck = 1'b0;
  logic        busy, done, err;

  logic [15:0] mem [64];
  assign buf_dat = mem[buf_adr];

  pcie_mwr_tx dut (
    .pcie_clk(pcie_clk), .rstn(rstn),
    .bus_num(bus_num), .dev_num(dev_num), .func_num(func_num),
    .start(start), .dma_addr(dma_addr), .dma_len(dma_len),
`ifdef PCIE_MWR_ADDR64_EN
    .dma_addr_hi(dma_addr_hi),
`endif
    .buf_adr(buf_adr), .buf_dat(buf_dat),
    .tx_req(tx_req), .tx_st(tx_st), .tx_end(tx_end), .tx_rdy(tx_rdy), .tx_data(tx_data),
    .tx_ca_ph(tx_ca_ph), .tx_ca_pd(tx_ca_pd), .tx_ca_p_recheck(tx_ca_p_recheck),
    .busy(busy), .done(done), .err(err)
  );

  always #4 pcie_clk = ~pcie_clk;

  typedef struct packed {
    logic [15:0] dat;
    logic [5:0]  adr;
    logic        pay;
    logic        st;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_err = 0;
  int   err_seen = 0;
  bit   in_pkt = 0;
  bit   done_due = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void push_w(logic [15:0] d, logic [5:0] a, logic p, logic s, logic l);
    exp_t e;
    e.dat = d; e.adr = a; e.pay = p; e.st = s; e.last = l;
    sb.push_back(e);
  endfunction

  // Reference TLP: header fields from the MWr layout, then the buffer words in order.
  function automatic void model_tlp(int len, logic [29:0] a, logic [31:0] hi);
    logic [31:0] lo;
    bit four;
    lo = {a, 2'b00};
    four = ADDR64 && (hi != 32'd0);
    push_w(four ? 16'h6000 : 16'h4000, 6'd0, 1'b0, 1'b1, 1'b0);
    push_w(16'(len), 6'd0, 1'b0, 1'b0, 1'b0);
    push_w({bus_num, dev_num, func_num}, 6'd0, 1'b0, 1'b0, 1'b0);
    push_w({8'h00, (len == 1) ? 4'h0 : 4'hF, 4'hF}, 6'd0, 1'b0, 1'b0, 1'b0);
    if (four) begin
      push_w(hi[31:16], 6'd0, 1'b0, 1'b0, 1'b0);
      push_w(hi[15:0], 6'd0, 1'b0, 1'b0, 1'b0);
    end
    push_w(lo[31:16], 6'd0, 1'b0, 1'b0, 1'b0);
    push_w(lo[15:0], 6'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2 * len; i++)
      push_w(mem[i], 6'(i), 1'b1, 1'b0, i == 2 * len - 1);
  endfunction

  always @(negedge pcie_clk) begin
    exp_t e;
    if (!rstn) begin
      in_pkt = 0;
      done_due = 0;
    end else begin
      if (done_due) chk("done_pulse", done, 1'b1);
      else if (done === 1'b1) chk("done_spurious", done, 1'b0);
      done_due = 0;
      if (err === 1'b1) err_seen++;
      if (tx_st === 1'b1 || in_pkt) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", {tx_st, tx_data}, 32'd0);
          in_pkt = 0;
        end else begin
          e = sb.pop_front();
          chk("tx_data", tx_data, e.dat);
          chk("tx_st", tx_st, e.st);
          chk("tx_end", tx_end, e.last);
          if (e.st) chk("req_off_at_st", tx_req, 1'b0);
          if (e.pay) chk("buf_adr", buf_adr, e.adr);
          in_pkt = !e.last;
          done_due = e.last;
        end
      end else begin
        chk("idle_bus", {tx_end, tx_data}, 32'd0);
      end
    end
  end

  task automatic rand_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
  endtask

  task automatic issue(input int len, input logic [29:0] a, input logic [31:0] hi, input bit ignored);
    @(posedge pcie_clk); #1;
    start = 1'b1; dma_len = 6'(len); dma_addr = a; dma_addr_hi = hi;
    if (!ignored) begin
      if (len >= 1 && len <= 32) model_tlp(len, a, hi);
      else exp_err++;
    end
    @(posedge pcie_clk); #1;
    start = 1'b0;
    // Scramble the launch inputs so only latched values can reach the header.
    bus_num = 8'($urandom); dev_num = 5'($urandom); func_num = 3'($urandom);
    dma_addr = 30'($urandom); dma_addr_hi = $urandom; dma_len = 6'($urandom);
  endtask

  task automatic wait_req();
    int n = 0;
    while (tx_req !== 1'b1 && n < 200) begin @(posedge pcie_clk); #1; n++; end
    chk("req_timeout", n < 200, 1'b1);
  endtask

  task automatic grant(input bit do_recheck, input int dly);
    wait_req();
    if (do_recheck) begin
      tx_ca_p_recheck = 1'b1;
      @(posedge pcie_clk); #1;
      tx_ca_p_recheck = 1'b0;
      chk("recheck_drop", {busy, tx_req}, 2'b10);
      wait_req();
    end
    repeat (dly) begin @(posedge pcie_clk); #1; end
    tx_rdy = 1'b1;
    @(posedge pcie_clk); #1;
    tx_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 400) begin @(posedge pcie_clk); #1; n++; end
    chk("idle_timeout", n < 400, 1'b1);
    repeat (2) @(posedge pcie_clk);
    #1;
  endtask

  task automatic wait_adr(input logic [5:0] a);
    int n = 0;
    while (buf_adr !== a && n < 200) begin @(negedge pcie_clk); n++; end
    chk("adr_timeout", n < 200, 1'b1);
  endtask

  task automatic credit_gate(input int len, input logic [8:0] ph_lo, input logic [12:0] pd_lo, input int cyc);
    int seen = 0;
    tx_ca_ph = ph_lo; tx_ca_pd = pd_lo;
    rand_mem();
    issue(len, 30'($urandom), 32'd0, 1'b0);
    repeat (cyc) begin @(negedge pcie_clk); if (tx_req === 1'b1) seen++; end
    chk("credit_hold", seen, 0);
    chk("credit_busy", busy, 1'b1);
    @(posedge pcie_clk); #1;
    tx_ca_ph = 9'd1; tx_ca_pd = 13'((len + 3) / 4);
    grant(1'b0, 0);
    wait_idle();
    tx_ca_ph = 9'h100; tx_ca_pd = 13'h1000;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hi;
    int len;
    #1 rstn = 1'b0;
    #1 chk("reset_outputs", {tx_req, tx_st, tx_end, busy, done, err, tx_data, buf_adr}, 32'd0);
    repeat (3) @(posedge pcie_clk);
    #1 rstn = 1'b1;

    // Minimal 1DW write with infinite credits.
    rand_mem();
    bus_num = 8'h02; dev_num = 5'd0; func_num = 3'd0;
    issue(1, 30'h0400_0010, 32'd0, 1'b0);
    grant(1'b0, 2);
    wait_idle();

    // Credit gating: pd short by one, ph at zero, and a small-length rounding case.
    credit_gate(32, 9'd1, 13'd7, 20);
    credit_gate(5, 9'd1, 13'd1, 8);
    credit_gate(3, 9'd0, 13'h1000, 8);

    // Recheck while waiting for the grant.
    rand_mem();
    issue(3, 30'($urandom), 32'd0, 1'b0);
    grant(1'b1, 1);
    wait_idle();

    // Illegal lengths.
    issue(0, 30'd0, 32'd0, 1'b0);
    issue(33, 30'd0, 32'd0, 1'b0);
    repeat (3) @(posedge pcie_clk);
    #1 chk("bad_len_idle", {busy, tx_req}, 2'b00);

    // Launch attempts while a packet is streaming.
    rand_mem();
    issue(6, 30'($urandom), 32'd0, 1'b0);
    grant(1'b0, 0);
    wait_adr(6'd3);
    issue(5, 30'($urandom), 32'd0, 1'b1);
    issue(0, 30'($urandom), 32'd0, 1'b1);
    wait_idle();
    repeat (4) @(posedge pcie_clk);
    #1 chk("ignored_start", {busy, tx_req}, 2'b00);

    // Reset in the middle of the payload.
    rand_mem();
    issue(8, 30'($urandom), 32'd0, 1'b0);
    grant(1'b0, 0);
    wait_adr(6'd5);
    #2 rstn = 1'b0;
    #1 chk("midpkt_reset", {tx_req, tx_st, tx_end, busy, done, err, tx_data, buf_adr}, 32'd0);
    sb.delete();
    repeat (2) @(posedge pcie_clk);
    #1 rstn = 1'b1;
    repeat (6) @(posedge pcie_clk);
    #1 chk("no_resume", {busy, tx_req}, 2'b00);
    rand_mem();
    issue(4, 30'($urandom), 32'd0, 1'b0);
    grant(1'b0, 0);
    wait_idle();

    // 64-bit address (only takes the 4DW form when the option is built in).
    rand_mem();
    issue(4, 30'($urandom), 32'h0000_0001, 1'b0);
    grant(1'b0, 0);
    wait_idle();

    // Randomized traffic.
    for (int it = 0; it < 16; it++) begin
      rand_mem();
      len = $urandom_range(1, 32);
      hi = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
      bus_num = 8'($urandom); dev_num = 5'($urandom); func_num = 3'($urandom);
      tx_ca_ph = ($urandom_range(0, 1) == 1) ? 9'h100 : 9'($urandom_range(1, 255));
      tx_ca_pd = ($urandom_range(0, 1) == 1) ? 13'h1000 : 13'((len + 3) / 4 + $urandom_range(0, 2));
      issue(len, 30'($urandom), hi, 1'b0);
      grant($urandom_range(0, 3) == 0, $urandom_range(0, 3));
      wait_idle();
    end

    repeat (5) @(posedge pcie_clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("err_count", err_seen, exp_err);
    chk("final_idle", {busy, tx_req}, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
